// File: rtl/network_mac_accum_requant.sv
`default_nettype none
// ============================================================================
//  Module      : network_mac_accum_requant
//  Description : Window accumulator for a conv layer. It sums signed products
//                over one window, rounds back to activation scale, adds the
//                channel bias, then saturates and applies an optional ReLU.
//  Revision    : 1.0  initial release
// ============================================================================
module network_mac_accum_requant #(
   parameter int PROD_WIDTH = 29,
   parameter int ACC_WIDTH  = 40,
   parameter int OUT_WIDTH  = 16,
   parameter int FRAC_SHIFT = 12,
   parameter int RELU_EN    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PROD_WIDTH-1:0] prod_in,
   input  logic                  prod_valid,
   input  logic                  prod_last,
   input  logic [OUT_WIDTH-1:0]  bias_in,
   output logic                  in_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           beat_cnt,
   output logic                  acc_ovf
);

   // Rounded value is one bit wider than the accumulator so the rounding add
   // cannot wrap. The biased value adds one more bit for the bias add.
   localparam int c_RW = ACC_WIDTH + 1;
   localparam int c_VW = ACC_WIDTH + 2;
   localparam logic [c_RW-1:0]        c_HALF     = c_RW'(2**(FRAC_SHIFT-1));
   localparam logic signed [c_VW-1:0] c_SAT_MAX  = c_VW'(2**(OUT_WIDTH-1) - 1);
   localparam logic signed [c_VW-1:0] c_SAT_MIN  = c_VW'(-(2**(OUT_WIDTH-1)));

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ACCUM = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic                    w_en;
   logic                    w_accept;
   logic [ACC_WIDTH-1:0]    w_prod_ext;
   logic [ACC_WIDTH-1:0]    w_acc_sum;
   logic [ACC_WIDTH-1:0]    w_sum;
   logic                    w_ovf;

   logic [ACC_WIDTH-1:0]    r_acc;
   logic [15:0]             r_beat_cnt;
   logic                    r_acc_ovf;

   // Stage A output: window sum and its bias
   logic                    r_a_valid;
   logic [ACC_WIDTH-1:0]    r_a_sum;
   logic [OUT_WIDTH-1:0]    r_a_bias;
   // Stage B output: sum with rounding constant added
   logic                    r_b_valid;
   logic [c_RW-1:0]         r_b_rnd;
   logic [OUT_WIDTH-1:0]    r_b_bias;
   // Stage C output: rounded value plus bias, before clipping
   logic                    r_c_valid;
   logic [c_VW-1:0]         r_c_v;

   logic signed [c_RW-1:0]  w_b_shift;
   logic [OUT_WIDTH-1:0]    w_sat;
   logic [OUT_WIDTH-1:0]    w_clip;

   logic                    r_out_valid;
   logic [OUT_WIDTH-1:0]    r_out_data;

   // A single advance enable stalls every stage together.
   assign w_en       = !r_out_valid || out_ready;
   assign w_accept   = prod_valid && w_en;

   assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_in[PROD_WIDTH-1]}}, prod_in};
   assign w_acc_sum  = r_acc + w_prod_ext;
   assign w_sum      = (r_state == S_IDLE) ? w_prod_ext : w_acc_sum;
   // Signed overflow only exists when adding to a running sum.
   assign w_ovf      = (r_state == S_ACCUM) &&
                       (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                       (w_acc_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

   // State register of the window-framing FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: any accepted beat either closes the window or keeps it open.
   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         w_state_nxt = prod_last ? S_IDLE : S_ACCUM;
      end
   end

   // Running accumulator, beat counter and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc      <= '0;
         r_beat_cnt <= '0;
         r_acc_ovf  <= 1'b0;
      end else if (w_accept) begin
         if (prod_last) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
         end else if (r_state == S_IDLE) begin
            r_acc      <= w_prod_ext;
            r_beat_cnt <= 16'd1;
         end else begin
            r_acc <= w_acc_sum;
            if (r_beat_cnt != 16'hFFFF) begin
               r_beat_cnt <= r_beat_cnt + 16'd1;
            end
         end
         if (w_ovf) begin
            r_acc_ovf <= 1'b1;
         end
      end
   end

   // Arithmetic shift of the rounded sum: round half up to activation scale.
   assign w_b_shift = $signed(r_b_rnd) >>> FRAC_SHIFT;

   // Clamp the biased value to the signed output range.
   always_comb begin
      w_sat = r_c_v[OUT_WIDTH-1:0];
      if ($signed(r_c_v) > c_SAT_MAX) begin
         w_sat = c_SAT_MAX[OUT_WIDTH-1:0];
      end else if ($signed(r_c_v) < c_SAT_MIN) begin
         w_sat = c_SAT_MIN[OUT_WIDTH-1:0];
      end
   end

   generate
      if (RELU_EN != 0) begin : g_relu
         // Negative activations become zero.
         always_comb begin
            w_clip = w_sat;
            if (w_sat[OUT_WIDTH-1]) begin
               w_clip = '0;
            end
         end
      end else begin : g_no_relu
         // Signed result passes through unchanged.
         always_comb begin
            w_clip = w_sat;
         end
      end
   endgenerate

   // Requantization pipeline: sum -> round -> bias -> clip, all held on stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a_valid   <= 1'b0;
         r_a_sum     <= '0;
         r_a_bias    <= '0;
         r_b_valid   <= 1'b0;
         r_b_rnd     <= '0;
         r_b_bias    <= '0;
         r_c_valid   <= 1'b0;
         r_c_v       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_en) begin
         r_a_valid   <= prod_valid && prod_last;
         r_a_sum     <= w_sum;
         r_a_bias    <= bias_in;
         r_b_valid   <= r_a_valid;
         r_b_rnd     <= {r_a_sum[ACC_WIDTH-1], r_a_sum} + c_HALF;
         r_b_bias    <= r_a_bias;
         r_c_valid   <= r_b_valid;
         r_c_v       <= {w_b_shift[c_RW-1], w_b_shift} +
                        {{(c_VW-OUT_WIDTH){r_b_bias[OUT_WIDTH-1]}}, r_b_bias};
         r_out_valid <= r_c_valid;
         if (r_c_valid) begin
            r_out_data <= w_clip;
         end
      end
   end

   assign in_ready  = w_en;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign beat_cnt  = r_beat_cnt;
   assign acc_ovf   = r_acc_ovf;

endmodule
`default_nettype wire

// File: tb/tb_network_mac_accum_requant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_network_mac_accum_requant
//  Description : Scoreboard bench. Two instances (ReLU off / on) share one
//                stimulus stream; each has its own queue of hand-computed
//                results, popped by a monitor on every output transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_network_mac_accum_requant;

   logic        clk = 1'b0;
   logic        reset;
   logic [28:0] prod_in;
   logic        prod_valid;
   logic        prod_last;
   logic [15:0] bias_in;
   logic        out_ready;
   logic        in_ready0, in_ready1;
   logic [15:0] out_data0, out_data1;
   logic        out_valid0, out_valid1;
   logic [15:0] beat_cnt0, beat_cnt1;
   logic        acc_ovf0, acc_ovf1;

   int n_pass  = 0;
   int n_total = 0;
   int q0[$];
   int q1[$];

   always #5 clk = ~clk;

   network_mac_accum_requant #(.RELU_EN(0)) u_dut0 (
      .clk(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid),
      .prod_last(prod_last), .bias_in(bias_in), .in_ready(in_ready0),
      .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
      .beat_cnt(beat_cnt0), .acc_ovf(acc_ovf0)
   );

   network_mac_accum_requant #(.RELU_EN(1)) u_dut1 (
      .clk(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid),
      .prod_last(prod_last), .bias_in(bias_in), .in_ready(in_ready1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
      .beat_cnt(beat_cnt1), .acc_ovf(acc_ovf1)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors: one time unit before each rising edge, a transfer pops the queue.
   always begin
      @(negedge clk);
      #4;
      if (!reset && out_valid0 && out_ready) begin
         if (q0.size() == 0) begin
            n_total++;
            $display("FAIL out0_unexpected: got %0d, expected no output", $signed(out_data0));
         end else begin
            check("out0", longint'($signed(out_data0)), longint'(q0.pop_front()));
         end
      end
   end

   always begin
      @(negedge clk);
      #4;
      if (!reset && out_valid1 && out_ready) begin
         if (q1.size() == 0) begin
            n_total++;
            $display("FAIL out1_unexpected: got %0d, expected no output", $signed(out_data1));
         end else begin
            check("out1", longint'($signed(out_data1)), longint'(q1.pop_front()));
         end
      end
   end

   // Offer one beat, hold it until accepted; returns 1 unit after the accepting edge.
   task automatic send_beat(input int p, input logic last, input int b);
      int guard;
      @(negedge clk);
      prod_in    = 29'(p);
      prod_last  = last;
      bias_in    = 16'(b);
      prod_valid = 1'b1;
      guard      = 0;
      forever begin
         #4;
         if (in_ready0) break;
         @(negedge clk);
         guard++;
         if (guard > 100) begin
            n_total++;
            $display("FAIL beat_timeout: got in_ready=0, expected 1 within 100 cycles");
            break;
         end
      end
      @(posedge clk);
      #1;
      prod_valid = 1'b0;
      prod_last  = 1'b0;
   endtask

   task automatic send_rep(input int p, input int n, input int b);
      for (int i = 0; i < n; i++) begin
         send_beat(p, (i == n - 1), b);
      end
   endtask

   task automatic expect_out(input int e0, input int e1);
      q0.push_back(e0);
      q1.push_back(e1);
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
   endtask

   task automatic stall_check();
      int          guard;
      logic [15:0] held;
      guard = 0;
      @(negedge clk);
      while (!out_valid0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("t4_pending", out_valid0, 1);
      out_ready = 1'b0;
      held = out_data0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t4_in_ready", in_ready0, 0);
         check("t4_hold_valid", out_valid0, 1);
         check("t4_hold_data", out_data0, held);
         @(negedge clk);
      end
      out_ready = 1'b1;
   endtask

   initial begin
      reset      = 1'b1;
      prod_in    = '0;
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      bias_in    = '0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_out_valid", out_valid0, 0);
      check("rst_out_data", out_data0, 0);
      check("rst_beat_cnt", beat_cnt0, 0);
      check("rst_acc_ovf", acc_ovf0, 0);
      check("rst_in_ready", in_ready0, 1);

      // T1: 4096+8192-4096 = 8192 -> 2, +5 -> 7, latency 3 edges
      expect_out(7, 7);
      send_beat(4096, 1'b0, 0);
      send_beat(8192, 1'b0, 0);
      check("t1_beat_cnt2", beat_cnt0, 2);
      send_beat(-4096, 1'b1, 5);
      check("t1_beat_cnt0", beat_cnt0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("t1_not_yet", out_valid0, 0);
      @(posedge clk);
      #1;
      check("t1_valid_at_3", out_valid0, 1);
      check("t1_data", $signed(out_data0), 7);
      drain();

      // T2: rounding, half up with arithmetic shift
      expect_out(2, 2);
      send_rep(6144, 1, 0);
      expect_out(-1, 0);
      send_rep(-6144, 1, 0);
      expect_out(-2, 0);
      send_rep(-6145, 1, 0);
      drain();

      // T3: saturation, 8 x 2^27 = 2^30 and 4 x -2^28 = -2^30
      expect_out(32767, 32767);
      send_rep(134217728, 8, 0);
      expect_out(-32768, 0);
      send_rep(-268435456, 4, 0);
      drain();

      // T4: back-pressure while results are pending
      expect_out(3, 3);
      expect_out(7, 7);
      expect_out(-10, 0);
      expect_out(4, 4);
      fork
         begin
            send_beat(4096, 1'b0, 0);
            send_beat(4096, 1'b1, 1);
            send_beat(-8192, 1'b0, 0);
            send_beat(-4096, 1'b1, 10);
            send_beat(40960, 1'b0, 0);
            send_beat(0, 1'b1, -20);
            send_beat(12288, 1'b0, 0);
            send_beat(4096, 1'b1, 0);
         end
         stall_check();
      join
      drain();

      // T5: single-beat windows, k*4096 -> k
      for (int k = 1; k <= 8; k++) begin
         expect_out(k, k);
         send_rep(k * 4096, 1, 0);
      end
      drain();

      // T6: reset mid-window discards it
      send_beat(4096, 1'b0, 0);
      send_beat(4096, 1'b0, 0);
      check("t6_beat_cnt_pre", beat_cnt0, 2);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t6_beat_cnt_rst", beat_cnt0, 0);
      check("t6_no_output", out_valid0, 0);
      drain();

      // T6: 4200 beats of 2^28-1; overflow first happens on beat 2049
      for (int i = 1; i <= 4200; i++) begin
         send_beat(268435455, 1'b0, 0);
         if (i == 2048) check("t6_ovf_before", acc_ovf0, 0);
         if (i == 2049) check("t6_ovf_set", acc_ovf0, 1);
      end
      check("t6_ovf_sticky0", acc_ovf0, 1);
      check("t6_ovf_sticky1", acc_ovf1, 1);
      check("t6_beat_cnt", beat_cnt0, 4200);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t6_ovf_cleared", acc_ovf0, 0);
      drain();

      check("q0_empty", q0.size(), 0);
      check("q1_empty", q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
